instr_fetch: RTL and testbench

Instruction fetch stage for the 16-bit simple architecture. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. It latches each returned 16-bit word into the instruction register, whose output feeds the opcode/condition field extractor directly downstream. It supports branch redirects from execute, including discarding an in-flight fetch.

---
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Instruction fetch stage: PC, imem req/ack handshake, instruction register.
// Branch redirects may squash an in-flight fetch, which is then drained before refetching.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, addr_n, ir_pc_n;
  logic [15:0]       ir_n;
  logic              ir_valid_n, req_n, ack;

  // An ack with no request outstanding (incl. the cycle after reset) is ignored.
  assign ack = imem_ack & imem_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      ir        <= 16'h0000;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      imem_addr <= addr_n;
      imem_req  <= req_n;
      ir        <= ir_n;
      ir_pc     <= ir_pc_n;
      ir_valid  <= ir_valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    addr_n     = imem_addr;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;

    if (branch_taken) begin
      pc_n       = branch_target;
      ir_valid_n = 1'b0;
      unique case (state)
        S_REQ, S_DRAIN: begin
          // A request on the bus cannot be withdrawn; wait for its ack before redirecting.
          if (ack || !imem_req) begin
            addr_n  = branch_target;
            state_n = S_REQ;
          end else begin
            state_n = S_DRAIN;
          end
        end
        S_HOLD: begin
          addr_n  = branch_target;
          state_n = S_REQ;
        end
        default: state_n = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (ack) begin
            ir_n       = imem_rdata;
            ir_pc_n    = imem_addr;
            ir_valid_n = 1'b1;
            pc_n       = pc + ADDR_W'(1);
            state_n    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_valid_n = 1'b0;
            addr_n     = pc;
            state_n    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (ack) begin
            addr_n  = pc;
            state_n = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end

    req_n = (state_n != S_HOLD);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - Self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_ack;
  logic [15:0] w_rdata;
  logic [15:0] w_ir;
  logic [15:0] w_ir_pc;
  logic        w_ir_valid;
  logic        w_ready;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] rdata;
    int          ack_delay;
    int          hold;
    logic [15:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata),
    .branch_taken(1'b0), .branch_target(16'h0000),
    .ir(w_ir), .ir_pc(w_ir_pc), .ir_valid(w_ir_valid), .ir_ready(w_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch_once(input logic [15:0] rdata, input int dly, input logic [15:0] addr);
    exp_t e;
    wait_req();
    check("fetch_addr", {16'd0, imem_addr}, {16'd0, addr});
    repeat (dly) step();
    check("addr_stable", {16'd0, imem_addr}, {16'd0, addr});
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    e.ir = rdata;
    e.pc = addr;
    sb.push_back(e);
    step();
    imem_ack = 1'b0;
    check("ir_valid_rise", {31'd0, ir_valid}, 32'd1);
    check("req_drop", {31'd0, imem_req}, 32'd0);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("ir", {16'd0, ir}, {16'd0, e.ir});
      check("ir_pc", {16'd0, ir_pc}, {16'd0, e.pc});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, {16'd0, imem_addr}, 32'd0);
    check({tag, "_ir"}, {16'd0, ir}, 32'd0);
    check({tag, "_ir_pc"}, {16'd0, ir_pc}, 32'd0);
    check({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = '{rdata: 16'hA5C3, ack_delay: 2, hold: 5, exp_addr: 16'h0000};
    vecs[1] = '{rdata: 16'h1111, ack_delay: 0, hold: 0, exp_addr: 16'h0001};
    vecs[2] = '{rdata: 16'hBEEF, ack_delay: 1, hold: 2, exp_addr: 16'h0002};
    vecs[3] = '{rdata: 16'h0F0F, ack_delay: 3, hold: 0, exp_addr: 16'h0003};

    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    branch_taken = 1'b0; branch_target = 16'h0000;
    ir_ready = 1'b0;
    w_ack = 1'b0; w_rdata = 16'h0000; w_ready = 1'b0;

    #12;
    check_reset_outputs("rst");
    step();
    #2 rst_n = 1'b1;
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", {16'd0, imem_addr}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      logic [15:0] held;
      fetch_once(vecs[i].rdata, vecs[i].ack_delay, vecs[i].exp_addr);
      held = ir;
      if (vecs[i].hold > 0) begin
        imem_ack = 1'b1;
        imem_rdata = 16'hFFFF;
        step();
        imem_ack = 1'b0;
        repeat (vecs[i].hold - 1) step();
        check("hold_ir_stable", {16'd0, ir}, {16'd0, held});
        check("hold_req_low", {31'd0, imem_req}, 32'd0);
        check("hold_valid", {31'd0, ir_valid}, 32'd1);
      end
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      check("consume_valid", {31'd0, ir_valid}, 32'd0);
      check("consume_req", {31'd0, imem_req}, 32'd1);
      check("consume_addr", {16'd0, imem_addr}, {16'd0, vecs[i].exp_addr + 16'd1});
    end

    // Branch while the fetch at 4 is outstanding: stale request drained, data dropped.
    step();
    branch_taken = 1'b1; branch_target = 16'h0040;
    step();
    branch_taken = 1'b0;
    check("drain_addr", {16'd0, imem_addr}, 32'h4);
    check("drain_req", {31'd0, imem_req}, 32'd1);
    step(); step();
    check("drain_addr_hold", {16'd0, imem_addr}, 32'h4);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    step();
    imem_ack = 1'b0;
    check("drain_drop_valid", {31'd0, ir_valid}, 32'd0);
    check("drain_drop_ir", {16'd0, ir}, 32'h0F0F);
    check("redirect_addr", {16'd0, imem_addr}, 32'h40);
    fetch_once(16'h1234, 1, 16'h0040);

    // Branch in HOLD with simultaneous ir_ready.
    branch_taken = 1'b1; branch_target = 16'h0100; ir_ready = 1'b1;
    step();
    branch_taken = 1'b0; ir_ready = 1'b0;
    check("hold_br_valid", {31'd0, ir_valid}, 32'd0);
    check("hold_br_addr", {16'd0, imem_addr}, 32'h100);
    check("hold_br_req", {31'd0, imem_req}, 32'd1);
    check("hold_br_ir", {16'd0, ir}, 32'h1234);

    // Branch coinciding with ack in REQ: data dropped, refetch at target.
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    branch_taken = 1'b1; branch_target = 16'h0200;
    step();
    imem_ack = 1'b0; branch_taken = 1'b0;
    check("req_br_ack_addr", {16'd0, imem_addr}, 32'h200);
    check("req_br_ack_valid", {31'd0, ir_valid}, 32'd0);
    check("req_br_ack_ir", {16'd0, ir}, 32'h1234);

    // Two branches while draining, then async reset between edges.
    branch_taken = 1'b1; branch_target = 16'h0300;
    step();
    branch_target = 16'h0380;
    step();
    branch_taken = 1'b0;
    check("drain2_addr", {16'd0, imem_addr}, 32'h200);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    #1 rst_n = 1'b1;
    step();
    check("rerun_req", {31'd0, imem_req}, 32'd1);
    check("rerun_addr", {16'd0, imem_addr}, 32'd0);
    fetch_once(16'h4321, 0, 16'h0000);

    // Wrap instance: PC 0xFFFF increments to 0x0000.
    check("wrap_addr", {16'd0, w_addr}, 32'hFFFF);
    check("wrap_req", {31'd0, w_req}, 32'd1);
    w_ack = 1'b1; w_rdata = 16'hCAFE;
    step();
    w_ack = 1'b0;
    check("wrap_ir", {16'd0, w_ir}, 32'hCAFE);
    check("wrap_ir_pc", {16'd0, w_ir_pc}, 32'hFFFF);
    check("wrap_valid", {31'd0, w_ir_valid}, 32'd1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    check("wrap_next_addr", {16'd0, w_addr}, 32'h0000);
    check("wrap_next_req", {31'd0, w_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
